// File: rtl/imem_boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   boot_state_t   : loader FSM states
//   HDR_BYTES      : length header size in bytes (16-bit word count)
//   BYTES_PER_WORD : stream bytes packed into one instruction word
//   CSUM_W         : width of the XOR checksum
package imem_boot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } boot_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Packs a big-endian byte stream into 32-bit words.
//   clock, reset : system clock, async active-low reset
//   clear        : restart packing at byte 0 of a word (new load)
//   byte_en      : a byte is accepted this cycle
//   byte_in      : accepted byte
//   word_valid   : this byte completes a word (combinational, one cycle)
//   word_out     : the completed word, valid with word_valid
// Only the three leading bytes are stored; the fourth is taken straight
// from byte_in so the parent can register the word on the accepting edge.
module byte_word_packer
  import imem_boot_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word_out
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [23:0]      shift_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_en) begin
      shift_q <= {shift_q[15:0], byte_in};
      cnt_q   <= (cnt_q == LAST_BYTE) ? '0 : cnt_q + 1'b1;
    end
  end

  assign word_valid = byte_en && (cnt_q == LAST_BYTE);
  assign word_out   = {shift_q, byte_in};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte image over
// valid/ready, writes it word by word into instruction memory and holds
// the core in reset until the image is complete and verified.
//   clock, reset     : system clock, async active-low reset
//   start            : one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   in_valid/in_data : byte stream source; in_ready is the accept signal
//   mem_we/addr/wdata: instruction-memory write port (addr is a byte address)
//   cpu_reset        : active-high core reset, released only in DONE
//   busy/done/error  : load status
//   words_loaded     : words written by the current or last load
// Stream: LEN_HI, LEN_LO (word count N), 4*N data bytes MSB first, then
// the XOR of all preceding bytes.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] words_loaded
);

  // Compared against the full 16-bit length so oversize images are caught
  // even when their low bits would fit the memory.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  boot_state_t       state_q, state_d;
  logic [15:0]       len_q;
  logic [CSUM_W-1:0] csum_q;
  logic [15:0]       new_len;
  logic              accept, start_ok, len_bad, last_word;
  logic              word_valid;
  logic [31:0]       word;

  assign accept   = in_valid && in_ready;
  assign start_ok = start && (state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign new_len  = {len_q[15:8], in_data};
  assign len_bad  = (new_len == 16'd0) || ({1'b0, new_len} > MAX_WORDS);
  // words_loaded still holds k while word k is completing.
  assign last_word = (16'(words_loaded) + 16'd1) == len_q;

  byte_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_ok),
    .byte_en    (accept && (state_q == S_DATA)),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word_out   (word)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d is given a default before the case so every path assigns
  // it; a missing assignment in combinational logic would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_HI;
      S_LEN_HI: if (accept) state_d = S_LEN_LO;
      S_LEN_LO: if (accept) state_d = len_bad ? S_ERROR : S_DATA;
      S_DATA:   if (word_valid && last_word) state_d = S_CSUM;
      S_CSUM:   if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status is a pure decode of the state register, so done/busy/cpu_reset
  // all change on the same edge that enters DONE or ERROR.
  assign in_ready  = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
  assign busy      = in_ready;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign cpu_reset = (state_q != S_DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q        <= '0;
      csum_q       <= '0;
      words_loaded <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        len_q        <= '0;
        csum_q       <= '0;
        words_loaded <= '0;
      end else begin
        if (accept && (state_q inside {S_LEN_HI, S_LEN_LO, S_DATA}))
          csum_q <= csum_q ^ in_data;
        if (accept && (state_q == S_LEN_HI)) len_q[15:8] <= in_data;
        if (accept && (state_q == S_LEN_LO)) len_q[7:0]  <= in_data;
        if (word_valid) begin
          mem_we       <= 1'b1;
          mem_addr     <= BASE_ADDR + (32'(words_loaded) << 2);
          mem_wdata    <= word;
          words_loaded <= words_loaded + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed loads from the test
// plan plus randomized loads, compared against a stream-level model.
module tb_imem_boot_loader;
  import imem_boot_pkg::*;

  localparam int          AW   = 8;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, mem_we, cpu_reset, busy, done, error;
  logic [31:0]   mem_addr, mem_wdata;
  logic [AW:0]   words_loaded;

  imem_boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  stream_q[$];
  logic [63:0] wr_q[$];
  logic [63:0] exp_wr_q[$];
  logic        exp_done, exp_error;
  int          exp_wl;

  // Every write seen on the memory port, one entry per mem_we cycle.
  always @(negedge clock) if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: derive expected writes and status from the stream alone.
  task automatic build_expect();
    int n;
    logic [7:0] x;
    exp_wr_q.delete();
    n = int'({stream_q[0], stream_q[1]});
    if (n == 0 || n > (1 << AW)) begin
      exp_done = 1'b0; exp_error = 1'b1; exp_wl = 0;
    end else begin
      for (int k = 0; k < n; k++)
        exp_wr_q.push_back({BASE + 32'(4 * k), stream_q[HDR_BYTES + 4*k],
                            stream_q[HDR_BYTES + 4*k + 1], stream_q[HDR_BYTES + 4*k + 2],
                            stream_q[HDR_BYTES + 4*k + 3]});
      x = 8'h00;
      for (int i = 0; i < HDR_BYTES + 4*n; i++) x ^= stream_q[i];
      exp_done  = (x == stream_q[HDR_BYTES + 4*n]);
      exp_error = !exp_done;
      exp_wl    = n;
    end
  endtask

  task automatic make_stream(input int n, input bit bad_csum);
    logic [7:0] x;
    logic [15:0] n16;
    n16 = 16'(n);
    stream_q.delete();
    stream_q.push_back(n16[15:8]);
    stream_q.push_back(n16[7:0]);
    if (n != 0 && n <= (1 << AW)) begin
      for (int i = 0; i < 4*n; i++) stream_q.push_back(8'($urandom));
      x = 8'h00;
      foreach (stream_q[i]) x ^= stream_q[i];
      stream_q.push_back(bad_csum ? (x ^ 8'(1 + $urandom_range(254, 0))) : x);
    end
  endtask

  task automatic make_nominal(input logic [7:0] last);
    stream_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h06, 8'h20, 8'h09, 8'h00, 8'h0B, last};
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),     64'd0);
    check({tag, "_mem_we"},    64'(mem_we),       64'd0);
    check({tag, "_mem_addr"},  64'(mem_addr),     64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata),    64'd0);
    check({tag, "_cpu_reset"}, 64'(cpu_reset),    64'd1);
    check({tag, "_busy"},      64'(busy),         64'd0);
    check({tag, "_done"},      64'(done),         64'd0);
    check({tag, "_error"},     64'(error),        64'd0);
    check({tag, "_words"},     64'(words_loaded), 64'd0);
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1; in_valid = 1'b0;
    @(negedge clock); start = 1'b0;
    check("start_busy",  64'(busy),         64'd1);
    check("start_cpurst", 64'(cpu_reset),   64'd1);
    check("start_done",  64'(done),         64'd0);
    check("start_error", 64'(error),        64'd0);
    check("start_words", 64'(words_loaded), 64'd0);
  endtask

  // Sends stream_q[0..count-1]; returns at the negedge after the last accept.
  task automatic send_bytes(input int count, input int max_gap, input bit poke);
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        @(negedge clock);
        in_valid = 1'b0; in_data = 8'($urandom); start = 1'b0;
      end
      @(negedge clock);
      in_valid = 1'b1; in_data = stream_q[i];
      start = poke && ($urandom_range(3, 0) == 0);
      check("in_ready", 64'(in_ready), 64'd1);
    end
    @(negedge clock);
    in_valid = 1'b0; in_data = 8'($urandom); start = 1'b0;
  endtask

  task automatic run_load(input string tag, input int max_gap, input bit poke);
    int nw;
    wr_q.delete();
    build_expect();
    pulse_start();
    send_bytes(stream_q.size(), max_gap, poke);
    repeat (3) @(negedge clock);
    check({tag, "_nwrites"}, 64'(wr_q.size()), 64'(exp_wr_q.size()));
    nw = (wr_q.size() < exp_wr_q.size()) ? wr_q.size() : exp_wr_q.size();
    for (int k = 0; k < nw; k++) check({tag, "_write"}, wr_q[k], exp_wr_q[k]);
    check({tag, "_done"},     64'(done),         64'(exp_done));
    check({tag, "_error"},    64'(error),        64'(exp_error));
    check({tag, "_cpurst"},   64'(cpu_reset),    64'(!exp_done));
    check({tag, "_busy"},     64'(busy),         64'd0);
    check({tag, "_in_ready"}, 64'(in_ready),     64'd0);
    check({tag, "_words"},    64'(words_loaded), 64'(exp_wl));
  endtask

  initial begin
    #1 check_reset_values("por");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("idle");

    make_nominal(8'h0E);
    run_load("nominal", 0, 1'b0);
    if (wr_q.size() == 2) begin
      check("nom_w0", wr_q[0], {32'h0000_0000, 32'h2008_0006});
      check("nom_w1", wr_q[1], {32'h0000_0004, 32'h2009_000B});
    end else check("nom_count", 64'(wr_q.size()), 64'd2);

    make_nominal(8'h0F);
    run_load("badcsum", 0, 1'b0);

    make_stream(0, 1'b0);
    run_load("zerolen", 0, 1'b0);

    make_stream(16'h0101, 1'b0);
    run_load("oversize", 0, 1'b0);

    make_stream(16'h0100, 1'b0);
    run_load("maxsize", 0, 1'b0);

    make_nominal(8'h0E);
    run_load("throttled", 3, 1'b0);

    // Reset after the 5th data byte: word 0 written, word 1 partial.
    make_nominal(8'h0E);
    wr_q.delete();
    pulse_start();
    send_bytes(HDR_BYTES + 5, 0, 1'b0);
    reset = 1'b0;
    #1 check_reset_values("midrst");
    check("midrst_nwr", 64'(wr_q.size()), 64'd1);
    repeat (3) @(negedge clock);
    check("midrst_nwr_hold", 64'(wr_q.size()), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    run_load("after_rst", 0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(7, 0) == 0) make_stream(($urandom_range(1, 0) == 0) ? 0 : 300, 1'b0);
      else make_stream($urandom_range(12, 1), $urandom_range(1, 0) == 1);
      run_load("random", 3, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream stage of the single-cycle MIPS core. Receives a byte-stream program image over a valid/ready interface and packs bytes into 32-bit words.
- Writes those words into instruction memory at consecutive word addresses.
- Holds the core in reset until the whole image has been written and its checksum verified. This replaces backdoor loading of instruction memory.

Parameters:
- ADDR_WIDTH, 8, log2 of instruction-memory depth in words; max image = 2**ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load.
- in_valid  in  1  byte present on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  32  byte address of the write.
- mem_wdata  out  32  word to write.
- cpu_reset  out  1  active-high reset to the core.
- busy  out  1  load in progress.
- done  out  1  last load succeeded.
- error  out  1  last load failed.
- words_loaded  out  ADDR_WIDTH+1  words written in the current or last load.

Behaviour:
- Reset values: state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0, done=0, error=0, words_loaded=0.
- Byte accept: a byte is consumed when in_valid&&in_ready is true at a rising edge. in_data is ignored otherwise.
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes with each word MSB first, then one checksum byte. The checksum is the XOR of every preceding byte, length bytes included.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR.
- in_ready=1 only in LEN_HI, LEN_LO, DATA and CSUM.
- start in IDLE, DONE or ERROR moves to LEN_HI on the next edge. It also:
  - clears done, error, words_loaded, the checksum accumulator and the byte counter;
  - sets busy=1 and cpu_reset=1.
- start in any other state is ignored.
- LEN_LO accept:
  - if N==0 or N>2**ADDR_WIDTH, go to ERROR; no memory write ever occurs for that load;
  - otherwise go to DATA.
- DATA:
  - Bytes shift into a 32-bit packer.
  - On acceptance of the 4th byte of word k (k from 0), the next cycle shows mem_we=1 for exactly one cycle, mem_addr=BASE_ADDR+4*k, mem_wdata=packed word.
  - words_loaded increments in that same cycle.
  - in_ready stays 1 during the write cycle, so back-to-back bytes sustain one write per 4 accepted bytes.
  - After word N-1 is accepted, go to CSUM.
- CSUM accept:
  - Received byte equals the accumulator: go to DONE. done=1, busy=0, cpu_reset=0, all registered on the same edge.
  - Mismatch: go to ERROR. error=1, busy=0, cpu_reset stays 1.
- Memory is already written when a checksum error is detected. The core stays in reset; recovery is a new start.
- DONE and ERROR hold until start or reset. IDLE holds cpu_reset=1.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Arithmetic:
  - mem_addr is computed modulo 2**32.
  - words_loaded never exceeds N.
  - The length check uses the full 16-bit N, with no truncation to ADDR_WIDTH.
- Reset mid-operation: all outputs return to reset values asynchronously. Any pending partial word is discarded and never written. Memory writes already issued are not undone.

Decomposition:
- Shared package imem_boot_pkg holds:
  - the state enumeration;
  - header length (2 bytes) and bytes-per-word (4) constants;
  - the checksum width.
- One sub-module, byte_word_packer, owns the 8-to-32-bit shift register, the byte-in-word counter (0..3) and the word_valid pulse.
- The top level holds the FSM, the length and word counters, the checksum and the memory-port registers.

Test Plan:
- Nominal load: start, then stream 00 02 20 08 00 06 20 09 00 0B 0E with in_valid held high. Required: two mem_we pulses, addr 0 = 20080006 and addr 4 = 2009000B; then done=1, cpu_reset=0, words_loaded=2, busy=0.
- Bad checksum: same stream ending in 0F instead of 0E. Required: both writes still occur; error=1, done=0, cpu_reset=1.
- Zero length: stream 00 00. Required: error=1 on the edge after LEN_LO, no mem_we ever, in_ready=0 afterwards.
- Oversize: with ADDR_WIDTH=8, LEN=0x0101. Required: error, no writes. LEN=0x0100 is accepted and proceeds to DATA.
- Throttled source: nominal stream with 0–3 idle cycles of in_valid=0 between bytes. Required: identical writes and final status; no byte is double-counted while in_valid is low.
- Reset mid-load: assert reset after 5 data-phase bytes (word 0 written, word 1 partial). Required:
  - immediate reset values on all outputs, no write of word 1;
  - a subsequent start and full nominal stream completes with done=1.
